spi_reg_master: RTL and testbench

SPI initiator for the 16-bit register frame spoken by the team's SPI register slave. The frame is a header byte followed by a data byte. Header bit 7 is write (1) or read (0); header [3:0] is the register address. On receipt of a local command, the block drives spi_cs/spi_clk/spi_mosi and captures spi_miso. It returns the slave's 8-bit status byte and the register read data. It sits on the host side of the board link, opposite the slave's register file.

---
 rtl/spi_reg_master.sv | 160 ++++++++++++++++
 tb/tb_spi_reg_master.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_reg_master.sv
// SPI initiator for the 16-bit header/data register frame (write bit, 4-bit address, data byte).
// Define SPI_REG_MASTER_MISO_SYNC_EN to pass spi_miso through a 2-flop synchronizer.
module spi_reg_master #(
  parameter int CLK_DIV = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       wr,
  input  logic [3:0] addr,
  input  logic [7:0] wdata,
  output logic       busy,
  output logic       done,
  output logic [7:0] rdata,
  output logic [7:0] status,
  output logic       spi_clk,
  output logic       spi_cs,
  output logic       spi_mosi,
  input  logic       spi_miso
);

  localparam logic [7:0] DIV_M1 = 8'(CLK_DIV - 1);

  typedef enum logic [2:0] {IDLE, SETUP, HIGH, LOW, GAP, DONE} state_t;

  state_t      state, state_next;
  logic [7:0]  div_cnt;
  logic [4:0]  bit_k;
  logic [15:0] tx_sr;
  logic [15:0] rx_sr;
  logic        miso_s;
  logic        phase_end;
  logic        accept;

`ifdef SPI_REG_MASTER_MISO_SYNC_EN
  logic [1:0] miso_sync;

  always_ff @(posedge clk) begin
    if (rst) miso_sync <= 2'b00;
    else     miso_sync <= {miso_sync[0], spi_miso};
  end

  assign miso_s = miso_sync[1];
`else
  assign miso_s = spi_miso;
`endif

  assign phase_end = (div_cnt == 8'd0);

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    accept     = 1'b0;
    busy       = 1'b0;
    done       = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          accept     = 1'b1;
          state_next = SETUP;
        end
      end
      SETUP: begin
        busy = 1'b1;
        if (phase_end) state_next = HIGH;
      end
      HIGH: begin
        busy = 1'b1;
        if (phase_end) state_next = LOW;
      end
      LOW: begin
        busy = 1'b1;
        if (phase_end) state_next = (bit_k == 5'd16) ? GAP : HIGH;
      end
      GAP: begin
        busy = 1'b1;
        if (phase_end) state_next = DONE;
      end
      DONE: begin
        done = 1'b1;
        if (start) begin
          accept     = 1'b1;
          state_next = SETUP;
        end else begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // SPI pins are driven from flops updated on phase transitions, so they never glitch.
  always_ff @(posedge clk) begin
    if (rst) begin
      div_cnt  <= 8'd0;
      bit_k    <= 5'd0;
      tx_sr    <= 16'd0;
      rx_sr    <= 16'd0;
      spi_cs   <= 1'b1;
      spi_clk  <= 1'b0;
      spi_mosi <= 1'b0;
      rdata    <= 8'd0;
      status   <= 8'd0;
    end else begin
      if (state_next != state || accept) div_cnt <= DIV_M1;
      else if (div_cnt != 8'd0)          div_cnt <= div_cnt - 8'd1;

      if (accept) begin
        tx_sr    <= {wr, 3'b000, addr, wdata};
        spi_cs   <= 1'b0;
        spi_mosi <= wr;
        bit_k    <= 5'd0;
      end

      case (state)
        SETUP: begin
          if (phase_end) begin
            spi_clk <= 1'b1;
            bit_k   <= 5'd1;
          end
        end
        HIGH: begin
          if (phase_end) begin
            spi_clk <= 1'b0;
            if (bit_k != 5'd16) begin
              tx_sr    <= {tx_sr[14:0], 1'b0};
              spi_mosi <= tx_sr[14];
            end else begin
              spi_mosi <= 1'b0;
            end
          end
        end
        // The slave moves MISO after the falling edge, so sample at the end of the low phase.
        LOW: begin
          if (phase_end) begin
            rx_sr <= {rx_sr[14:0], miso_s};
            if (bit_k == 5'd16) begin
              spi_cs <= 1'b1;
            end else begin
              spi_clk <= 1'b1;
              bit_k   <= bit_k + 5'd1;
            end
          end
        end
        GAP: begin
          if (phase_end) begin
            rdata  <= rx_sr[7:0];
            status <= rx_sr[15:8];
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_reg_master.sv
// Self-checking bench for spi_reg_master: D=4 and D=8 instances share a behavioral register slave.
module tb_spi_reg_master;

  localparam logic [7:0] STATUS = 8'h3C;

  logic       clk;
  logic       rst;
  logic       tb_rst;
  logic       sel;
  logic       start_req;
  logic       wr;
  logic [3:0] addr;
  logic [7:0] wdata;

  logic       busy4, done4, sclk4, cs4, mosi4;
  logic [7:0] rdata4, status4;
  logic       busy8, done8, sclk8, cs8, mosi8;
  logic [7:0] rdata8, status8;

  logic       s_miso;
  logic       s_cs, s_sclk, s_mosi;
  logic       busy_m, done_m;
  logic [7:0] rdata_m, status_m;

  int tests;
  int errors;

  spi_reg_master #(.CLK_DIV(4)) dut4 (
    .clk(clk), .rst(rst), .start(start_req & ~sel), .wr(wr), .addr(addr), .wdata(wdata),
    .busy(busy4), .done(done4), .rdata(rdata4), .status(status4),
    .spi_clk(sclk4), .spi_cs(cs4), .spi_mosi(mosi4), .spi_miso(s_miso)
  );

  spi_reg_master #(.CLK_DIV(8)) dut8 (
    .clk(clk), .rst(rst), .start(start_req & sel), .wr(wr), .addr(addr), .wdata(wdata),
    .busy(busy8), .done(done8), .rdata(rdata8), .status(status8),
    .spi_clk(sclk8), .spi_cs(cs8), .spi_mosi(mosi8), .spi_miso(s_miso)
  );

  assign s_cs     = sel ? cs8 : cs4;
  assign s_sclk   = sel ? sclk8 : sclk4;
  assign s_mosi   = sel ? mosi8 : mosi4;
  assign busy_m   = sel ? busy8 : busy4;
  assign done_m   = sel ? done8 : done4;
  assign rdata_m  = sel ? rdata8 : rdata4;
  assign status_m = sel ? status8 : status4;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioral register slave: samples MOSI on rising edges, moves MISO after falling edges.
  logic [7:0]  regs [16];
  logic        s_cs_q, s_sclk_q;
  logic [15:0] s_rx;
  logic [7:0]  s_hdr;
  int          s_rcnt, s_fcnt;
  logic [15:0] s_last_frame;
  int          s_edges_last;
  logic [15:0] s_resp;
  int          done_cnt4;

  always_comb begin
    s_resp = {STATUS, 8'h00};
    if (!s_hdr[7]) s_resp[7:0] = regs[s_hdr[3:0]];
  end

  always @(posedge clk) begin
    s_cs_q   <= s_cs;
    s_sclk_q <= s_sclk;
    if (tb_rst) begin
      for (int i = 0; i < 16; i++) regs[i] <= 8'h00;
      s_miso <= 1'b0; s_rcnt <= 0; s_fcnt <= 0; s_rx <= 16'h0; s_hdr <= 8'h0;
      s_last_frame <= 16'h0; s_edges_last <= 0; done_cnt4 <= 0;
    end else begin
      if (done4) done_cnt4 <= done_cnt4 + 1;
      if (s_cs) begin
        s_rcnt <= 0; s_fcnt <= 0; s_miso <= 1'b0;
        if (!s_cs_q) begin
          s_last_frame <= s_rx;
          s_edges_last <= s_rcnt;
        end
      end else begin
        if (s_sclk && !s_sclk_q) begin
          s_rx   <= {s_rx[14:0], s_mosi};
          s_rcnt <= s_rcnt + 1;
          if (s_rcnt == 7) s_hdr <= {s_rx[6:0], s_mosi};
          if (s_rcnt == 15 && s_rx[14]) regs[s_rx[10:7]] <= {s_rx[6:0], s_mosi};
        end
        if (!s_sclk && s_sclk_q && s_fcnt < 16) begin
          s_fcnt <= s_fcnt + 1;
          s_miso <= s_resp[15 - s_fcnt];
        end
      end
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Issues one command on the selected instance and returns the cycle done was seen (accept = 0).
  task automatic applyStimulus(input logic w, input logic [3:0] a, input logic [7:0] d,
                               output int cyc);
    int guard;
    guard = 0;
    while (busy_m && guard < 2000) begin
      @(posedge clk); #1; guard++;
    end
    wr = w; addr = a; wdata = d; start_req = 1'b1;
    @(posedge clk); #1;
    start_req = 1'b0;
    cyc = 1;
    while (!done_m && cyc < 1000) begin
      @(posedge clk); #1; cyc++;
    end
    if (!done_m) checkOutput("done_timeout", 32'(cyc), 32'd0);
  endtask

  typedef struct {
    logic        wr;
    logic [3:0]  addr;
    logic [7:0]  wdata;
    logic [7:0]  exp_rdata;
    logic [15:0] exp_frame;
  } vec_t;

  vec_t vecs [7];
  int   cyc;
  int   cs_high;
  int   dc0;

  initial begin
    vecs[0] = '{1'b1, 4'd5,  8'hA5, 8'h00, 16'h85A5};
    vecs[1] = '{1'b0, 4'd5,  8'h00, 8'hA5, 16'h0500};
    vecs[2] = '{1'b1, 4'd15, 8'h5A, 8'h00, 16'h8F5A};
    vecs[3] = '{1'b1, 4'd0,  8'hFF, 8'h00, 16'h80FF};
    vecs[4] = '{1'b0, 4'd0,  8'h00, 8'hFF, 16'h0000};
    vecs[5] = '{1'b0, 4'd15, 8'h00, 8'h5A, 16'h0F00};
    vecs[6] = '{1'b0, 4'd3,  8'h00, 8'h00, 16'h0300};

    tests = 0; errors = 0;
    sel = 1'b0; start_req = 1'b0; wr = 1'b0; addr = 4'd0; wdata = 8'd0;
    rst = 1'b1; tb_rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset_cs", 32'(cs4), 32'd1);
    checkOutput("reset_sclk", 32'(sclk4), 32'd0);
    checkOutput("reset_mosi", 32'(mosi4), 32'd0);
    checkOutput("reset_busy", 32'(busy4), 32'd0);
    checkOutput("reset_done", 32'(done4), 32'd0);
    checkOutput("reset_rdata", 32'(rdata4), 32'd0);
    checkOutput("reset_status", 32'(status4), 32'd0);
    checkOutput("reset_cs8", 32'(cs8), 32'd1);
    rst = 1'b0; tb_rst = 1'b0;
    @(posedge clk); #1;

    for (int i = 0; i < 7; i++) begin
      applyStimulus(vecs[i].wr, vecs[i].addr, vecs[i].wdata, cyc);
      checkOutput($sformatf("v%0d_done_cycle", i), 32'(cyc), 32'd137);
      checkOutput($sformatf("v%0d_busy_at_done", i), 32'(busy4), 32'd0);
      checkOutput($sformatf("v%0d_rdata", i), 32'(rdata4), 32'(vecs[i].exp_rdata));
      checkOutput($sformatf("v%0d_status", i), 32'(status4), 32'(STATUS));
      checkOutput($sformatf("v%0d_mosi_frame", i), 32'(s_last_frame), 32'(vecs[i].exp_frame));
      checkOutput($sformatf("v%0d_sclk_edges", i), 32'(s_edges_last), 32'd16);
      @(posedge clk); #1;
      checkOutput($sformatf("v%0d_done_width", i), 32'(done4), 32'd0);
    end

    // Start while busy: a write request at cycle 50 of a read must be dropped.
    dc0 = done_cnt4;
    wr = 1'b0; addr = 4'd5; wdata = 8'h00; start_req = 1'b1;
    @(posedge clk); #1;
    start_req = 1'b0;
    cyc = 1;
    while (!done4 && cyc < 1000) begin
      @(posedge clk); #1; cyc++;
      if (cyc == 50) begin start_req = 1'b1; wr = 1'b1; addr = 4'd9; wdata = 8'hEE; end
      if (cyc == 51) start_req = 1'b0;
    end
    checkOutput("busy_start_done_cycle", 32'(cyc), 32'd137);
    checkOutput("busy_start_rdata", 32'(rdata4), 32'hA5);
    checkOutput("busy_start_frame", 32'(s_last_frame), 32'h0500);
    repeat (20) @(posedge clk);
    #1;
    checkOutput("busy_start_done_count", 32'(done_cnt4 - dc0), 32'd1);
    checkOutput("busy_start_idle", 32'(busy4), 32'd0);
    checkOutput("busy_start_reg9", 32'(regs[9]), 32'd0);

    // Back-to-back: start held high, the DONE cycle accepts the follow-up read.
    wr = 1'b1; addr = 4'd7; wdata = 8'h11; start_req = 1'b1;
    @(posedge clk); #1;
    wr = 1'b0; wdata = 8'h00;
    cyc = 1; cs_high = 0;
    while (!done4 && cyc < 1000) begin
      @(posedge clk); #1; cyc++;
      if (cs4) cs_high++;
    end
    checkOutput("b2b_first_done", 32'(cyc), 32'd137);
    checkOutput("b2b_first_rdata", 32'(rdata4), 32'h00);
    checkOutput("b2b_first_frame", 32'(s_last_frame), 32'h8711);
    checkOutput("b2b_cs_high_cycles", 32'(cs_high), 32'd5);
    @(posedge clk); #1; cyc++;
    checkOutput("b2b_second_accepted", 32'(busy4), 32'd1);
    while (!done4 && cyc < 1000) begin
      @(posedge clk); #1; cyc++;
    end
    start_req = 1'b0;
    checkOutput("b2b_second_done", 32'(cyc), 32'd274);
    checkOutput("b2b_second_rdata", 32'(rdata4), 32'h11);
    checkOutput("b2b_second_status", 32'(status4), 32'(STATUS));
    @(posedge clk); #1;
    checkOutput("b2b_frame2", 32'(s_last_frame), 32'h0700);
    checkOutput("b2b_stops", 32'(busy4), 32'd0);

    // Reset at cycle 60 of a read aborts it without a done pulse.
    dc0 = done_cnt4;
    wr = 1'b0; addr = 4'd5; start_req = 1'b1;
    @(posedge clk); #1;
    start_req = 1'b0;
    cyc = 1;
    while (cyc < 60) begin
      @(posedge clk); #1; cyc++;
    end
    rst = 1'b1;
    @(posedge clk); #1;
    checkOutput("rst_mid_cs", 32'(cs4), 32'd1);
    checkOutput("rst_mid_sclk", 32'(sclk4), 32'd0);
    checkOutput("rst_mid_mosi", 32'(mosi4), 32'd0);
    checkOutput("rst_mid_busy", 32'(busy4), 32'd0);
    checkOutput("rst_mid_done", 32'(done4), 32'd0);
    checkOutput("rst_mid_rdata", 32'(rdata4), 32'd0);
    checkOutput("rst_mid_status", 32'(status4), 32'd0);
    rst = 1'b0;
    repeat (150) @(posedge clk);
    #1;
    checkOutput("rst_mid_no_done", 32'(done_cnt4 - dc0), 32'd0);
    checkOutput("rst_mid_stays_idle", 32'(busy4), 32'd0);
    applyStimulus(1'b0, 4'd5, 8'h00, cyc);
    checkOutput("rst_after_read_cycle", 32'(cyc), 32'd137);
    checkOutput("rst_after_read_rdata", 32'(rdata4), 32'hA5);

    // Divider variant on the D=8 instance.
    @(posedge clk); #1;
    sel = 1'b1;
    @(posedge clk); #1;
    applyStimulus(1'b0, 4'd15, 8'h00, cyc);
    checkOutput("div8_done_cycle", 32'(cyc), 32'd273);
    checkOutput("div8_rdata", 32'(rdata8), 32'h5A);
    checkOutput("div8_status", 32'(status8), 32'(STATUS));
    checkOutput("div8_frame", 32'(s_last_frame), 32'h0F00);
    checkOutput("div8_sclk_edges", 32'(s_edges_last), 32'd16);

    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end

endmodule
